// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program-counter generator:
// next-PC source select and default reset vector / step.
package pc_pkg;

   typedef enum logic [2:0] {
      SRC_RESET,
      SRC_FLUSH,
      SRC_HOLD,
      SRC_BRANCH,
      SRC_PEND,
      SRC_SEQ
   } pc_src_e;

   localparam logic [31:0] PC_RESET_VEC_DEF = 32'h0000_0000;
   localparam int unsigned PC_STEP_DEF      = 4;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-control bundle between the pipeline and pc_gen: redirect requests
// in, registered fetch address and status out.
interface pc_gen_if #(
   parameter int ADDR_W = 32
);
   logic              stall_i;
   logic              flush_i;
   logic [ADDR_W-1:0] flush_pc_i;
   logic              branch_flag_i;
   logic [ADDR_W-1:0] branch_target_address_i;
   logic [ADDR_W-1:0] pc;
   logic              ce;
   logic              pend_o;
   logic              misalign_o;

   modport master (
      output stall_i, flush_i, flush_pc_i, branch_flag_i, branch_target_address_i,
      input  pc, ce, pend_o, misalign_o
   );

   modport slave (
      input  stall_i, flush_i, flush_pc_i, branch_flag_i, branch_target_address_i,
      output pc, ce, pend_o, misalign_o
   );
endinterface

// File: rtl/pc_pend_buf.sv
// One-entry pending-branch buffer: holds a branch target resolved while fetch
// is stalled until the stall drops. Clear has priority over load.
module pc_pend_buf #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clr,
   input  logic [ADDR_W-1:0] load_addr,
   output logic              valid,
   output logic [ADDR_W-1:0] addr
);

   always_ff @(posedge clk) begin
      if (rst || clr)
         valid <= 1'b0;
      else if (load)
         valid <= 1'b1;
   end

   // Address is qualified by valid, so it carries no reset.
   always_ff @(posedge clk) begin
      if (load)
         addr <= load_addr;
   end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator with reset vector, stall hold, flush redirect and
// pending-branch buffer. Optional misalignment flag: PC_MISALIGN_CHECK_EN.
module pc_gen
   import pc_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(PC_RESET_VEC_DEF),
   parameter int unsigned       STEP      = PC_STEP_DEF
) (
   input  logic     clk,
   input  logic     rst,
   pc_gen_if.slave  bus
);

   localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);

   pc_src_e           src;
   logic [ADDR_W-1:0] next_pc;
   logic [ADDR_W-1:0] pc_q;
   logic              ce_q;
   logic              mis_q;
   logic              pend_valid;
   logic [ADDR_W-1:0] pend_addr;
   logic              pend_load;
   logic              pend_clr;

   // A cycle with ce=0 is the enable-delay slot after reset: still at RESET_VEC.
   always_comb begin
      src     = SRC_SEQ;
      next_pc = pc_q + STEP_V;
      if (rst || !ce_q) begin
         src     = SRC_RESET;
         next_pc = RESET_VEC;
      end else if (bus.flush_i) begin
         src     = SRC_FLUSH;
         next_pc = bus.flush_pc_i;
      end else if (bus.stall_i) begin
         src     = SRC_HOLD;
         next_pc = pc_q;
      end else if (bus.branch_flag_i) begin
         src     = SRC_BRANCH;
         next_pc = bus.branch_target_address_i;
      end else if (pend_valid) begin
         src     = SRC_PEND;
         next_pc = pend_addr;
      end
   end

   // Only a stall keeps the buffer; every other source consumes or discards it.
   assign pend_load = (src == SRC_HOLD) && bus.branch_flag_i;
   assign pend_clr  = (src != SRC_HOLD);

   pc_pend_buf #(.ADDR_W(ADDR_W)) u_pend (
      .clk       (clk),
      .rst       (rst),
      .load      (pend_load),
      .clr       (pend_clr),
      .load_addr (bus.branch_target_address_i),
      .valid     (pend_valid),
      .addr      (pend_addr)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         ce_q <= 1'b0;
         pc_q <= RESET_VEC;
      end else begin
         ce_q <= 1'b1;
         pc_q <= next_pc;
      end
   end

`ifdef PC_MISALIGN_CHECK_EN
   localparam logic [ADDR_W-1:0] ALIGN_MASK = STEP_V - ADDR_W'(1);

   // Evaluated on the value being loaded, so holds keep the flag and
   // increments from a misaligned PC keep it set.
   always_ff @(posedge clk) begin
      if (rst || src == SRC_RESET)
         mis_q <= 1'b0;
      else
         mis_q <= |(next_pc & ALIGN_MASK);
   end
`else
   assign mis_q = 1'b0;
`endif

   assign bus.pc         = pc_q;
   assign bus.ce         = ce_q;
   assign bus.pend_o     = pend_valid;
   assign bus.misalign_o = mis_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a 32-bit instance (reset vector 0xBFC00000)
// and an 8-bit instance for wrap and reset-during-stall behaviour.
module tb_pc_gen;

   typedef struct {
      int unsigned tag;
      logic [31:0] pc;
      logic        ce;
      logic        pend;
      logic        mis;
      string       name;
   } exp_t;

`ifdef PC_MISALIGN_CHECK_EN
   localparam logic MIS = 1'b1;
`else
   localparam logic MIS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   int unsigned cyc = 0;
   int total = 0;
   int bad = 0;
   exp_t qa[$];
   exp_t qb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pc_gen_if #(.ADDR_W(32)) ifa ();
   pc_gen_if #(.ADDR_W(8))  ifb ();

   pc_gen #(.ADDR_W(32), .RESET_VEC(32'hBFC0_0000), .STEP(4)) dut_a (
      .clk (clk),
      .rst (rst_a),
      .bus (ifa)
   );

   pc_gen #(.ADDR_W(8), .RESET_VEC(8'h10), .STEP(4)) dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (ifb)
   );

   task automatic check(input exp_t e, input logic [31:0] apc, input logic ace,
                        input logic apend, input logic amis);
      total++;
      if (apc !== e.pc || ace !== e.ce || apend !== e.pend || amis !== e.mis) begin
         bad++;
         $display("FAIL %s: got pc=%h ce=%b pend=%b mis=%b, expected pc=%h ce=%b pend=%b mis=%b",
                  e.name, apc, ace, apend, amis, e.pc, e.ce, e.pend, e.mis);
      end
   endtask

   // Monitor: compare every expectation tagged for the edge just taken.
   always @(posedge clk) begin
      exp_t e;
      #1;
      while (qa.size() > 0 && qa[0].tag <= cyc) begin
         e = qa.pop_front();
         check(e, ifa.pc, ifa.ce, ifa.pend_o, ifa.misalign_o);
      end
      while (qb.size() > 0 && qb[0].tag <= cyc) begin
         e = qb.pop_front();
         check(e, {24'h0, ifb.pc}, ifb.ce, ifb.pend_o, ifb.misalign_o);
      end
   end

   task automatic drv_a(input logic r, input logic s, input logic f, input logic [31:0] fpc,
                        input logic b, input logic [31:0] bt, input logic [31:0] epc,
                        input logic ece, input logic epend, input logic emis, input string nm);
      @(negedge clk);
      rst_a                      = r;
      ifa.stall_i                = s;
      ifa.flush_i                = f;
      ifa.flush_pc_i             = fpc;
      ifa.branch_flag_i          = b;
      ifa.branch_target_address_i = bt;
      qa.push_back('{tag: cyc + 1, pc: epc, ce: ece, pend: epend, mis: emis, name: nm});
   endtask

   task automatic drv_b(input logic r, input logic s, input logic f, input logic [7:0] fpc,
                        input logic b, input logic [7:0] bt, input logic [7:0] epc,
                        input logic ece, input logic epend, input string nm);
      @(negedge clk);
      rst_b                      = r;
      ifb.stall_i                = s;
      ifb.flush_i                = f;
      ifb.flush_pc_i             = fpc;
      ifb.branch_flag_i          = b;
      ifb.branch_target_address_i = bt;
      qb.push_back('{tag: cyc + 1, pc: {24'h0, epc}, ce: ece, pend: epend, mis: 1'b0, name: nm});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ifa.stall_i = 0; ifa.flush_i = 0; ifa.flush_pc_i = 0;
      ifa.branch_flag_i = 0; ifa.branch_target_address_i = 0;
      ifb.stall_i = 0; ifb.flush_i = 0; ifb.flush_pc_i = 0;
      ifb.branch_flag_i = 0; ifb.branch_target_address_i = 0;

      // 32-bit instance: r  s  f  fpc           b  bt            pc            ce pe mis
      for (int i = 0; i < 3; i++)
         drv_a(1, 0, 0, 32'h0,        0, 32'h0,     32'hBFC0_0000, 0, 0, 0, "reset_hold");
      drv_a(0, 0, 0, 32'h0,           0, 32'h0,     32'hBFC0_0000, 1, 0, 0, "first_fetch");
      drv_a(0, 0, 0, 32'h0,           0, 32'h0,     32'hBFC0_0004, 1, 0, 0, "seq_1");
      drv_a(0, 0, 0, 32'h0,           0, 32'h0,     32'hBFC0_0008, 1, 0, 0, "seq_2");
      drv_a(0, 0, 1, 32'h100,         0, 32'h0,     32'h0000_0100, 1, 0, 0, "flush_to_100");
      drv_a(0, 0, 0, 32'h0,           1, 32'h400,   32'h0000_0400, 1, 0, 0, "branch_400");
      drv_a(0, 0, 0, 32'h0,           0, 32'h0,     32'h0000_0404, 1, 0, 0, "after_branch");
      drv_a(0, 1, 0, 32'h0,           1, 32'h800,   32'h0000_0404, 1, 1, 0, "stall_branch");
      drv_a(0, 1, 0, 32'h0,           0, 32'h0,     32'h0000_0404, 1, 1, 0, "stall_hold_1");
      drv_a(0, 1, 0, 32'h0,           0, 32'h0,     32'h0000_0404, 1, 1, 0, "stall_hold_2");
      drv_a(0, 0, 0, 32'h0,           0, 32'h0,     32'h0000_0800, 1, 0, 0, "pend_release");
      drv_a(0, 0, 0, 32'h0,           0, 32'h0,     32'h0000_0804, 1, 0, 0, "after_pend");
      drv_a(0, 1, 0, 32'h0,           1, 32'h800,   32'h0000_0804, 1, 1, 0, "stall_branch_2");
      drv_a(0, 1, 1, 32'h8000_0180,   0, 32'h0,     32'h8000_0180, 1, 0, 0, "flush_over_stall");
      drv_a(0, 0, 0, 32'h0,           0, 32'h0,     32'h8000_0184, 1, 0, 0, "flush_drops_pend");
      drv_a(0, 1, 0, 32'h0,           1, 32'hA00,   32'h8000_0184, 1, 1, 0, "stall_branch_3");
      drv_a(0, 0, 0, 32'h0,           1, 32'hB00,   32'h0000_0B00, 1, 0, 0, "live_beats_pend");
      drv_a(0, 0, 0, 32'h0,           0, 32'h0,     32'h0000_0B04, 1, 0, 0, "pend_consumed");
      drv_a(0, 0, 1, 32'hC00,         1, 32'hD00,   32'h0000_0C00, 1, 0, 0, "flush_beats_branch");
      drv_a(0, 0, 0, 32'h0,           1, 32'h402,   32'h0000_0402, 1, 0, MIS, "misalign_branch");
      drv_a(0, 0, 0, 32'h0,           0, 32'h0,     32'h0000_0406, 1, 0, MIS, "misalign_seq");
      drv_a(0, 0, 0, 32'h0,           1, 32'h500,   32'h0000_0500, 1, 0, 0, "align_clears");
      drv_a(0, 0, 1, 32'h601,         0, 32'h0,     32'h0000_0601, 1, 0, MIS, "misalign_flush");
      drv_a(1, 0, 0, 32'h0,           0, 32'h0,     32'hBFC0_0000, 0, 0, 0, "reset_while_on");
      drv_a(0, 0, 0, 32'h0,           0, 32'h0,     32'hBFC0_0000, 1, 0, 0, "reenable");
      drv_a(0, 0, 0, 32'h0,           0, 32'h0,     32'hBFC0_0004, 1, 0, 0, "reenable_seq");

      // 8-bit instance, RESET_VEC=0x10
      drv_b(1, 0, 0, 8'h0,  0, 8'h0,  8'h10, 0, 0, "b_reset");
      drv_b(0, 0, 0, 8'h0,  0, 8'h0,  8'h10, 1, 0, "b_first_fetch");
      drv_b(0, 0, 1, 8'hF8, 0, 8'h0,  8'hF8, 1, 0, "b_flush_F8");
      drv_b(0, 0, 0, 8'h0,  0, 8'h0,  8'hFC, 1, 0, "b_seq_FC");
      drv_b(0, 0, 0, 8'h0,  0, 8'h0,  8'h00, 1, 0, "b_wrap");
      drv_b(0, 0, 0, 8'h0,  0, 8'h0,  8'h04, 1, 0, "b_after_wrap");
      drv_b(0, 1, 0, 8'h0,  1, 8'h40, 8'h04, 1, 1, "b_stall_branch");
      drv_b(1, 1, 0, 8'h0,  0, 8'h0,  8'h10, 0, 0, "b_reset_mid_stall");
      drv_b(0, 0, 0, 8'h0,  0, 8'h0,  8'h10, 1, 0, "b_pend_discarded");
      drv_b(0, 0, 0, 8'h0,  0, 8'h0,  8'h14, 1, 0, "b_seq_after");

      repeat (3) @(negedge clk);
      total++;
      if (qa.size() != 0 || qb.size() != 0) begin
         bad++;
         $display("FAIL drain: unchecked entries a=%0d b=%0d, expected 0", qa.size(), qb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
